// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : quad_decoder
//  Description : Full-resolution (x4) quadrature decoder. Turns the two
//                debounced encoder phases into a one-cycle step pulse, a
//                direction flag and a wrapping W-bit position counter.
//                Double-bit phase jumps are flagged on a sticky error bit.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1  system clock, rising edge
//    rst    in   1  asynchronous reset, active low
//    a      in   1  debounced phase A (already synchronous to clk)
//    b      in   1  debounced phase B (already synchronous to clk)
//    clr    in   1  synchronous clear of count and err, active high
//    count  out  W  position counter, wraps modulo 2^W
//    step   out  1  one-cycle pulse per counted edge
//    dir    out  1  direction of last counted edge (1 = up, 0 = down)
//    err    out  1  sticky illegal-transition flag
// ============================================================================
module quad_decoder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         b,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         step,
  output logic         dir,
  output logic         err
);

  // --------------------------------------------------------------------------
  // FSM encoding
  // --------------------------------------------------------------------------
  localparam logic [0:0] c_ST_INIT  = 1'b0;
  localparam logic [0:0] c_ST_TRACK = 1'b1;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [0:0]   state_q, state_d;
  logic [1:0]   ab_q,    ab_d;
  logic [W-1:0] count_q, count_d;
  logic         step_q,  step_d;
  logic         dir_q,   dir_d;
  logic         err_q,   err_d;

  // Current phase pair, MSB = A
  logic [1:0]   w_ab;

  // Edge classification of ab_q -> w_ab
  logic         w_up;
  logic         w_dn;
  logic         w_bad;

  assign w_ab = {a, b};

  // --------------------------------------------------------------------------
  // Edge classification. Up order is 00 -> 10 -> 11 -> 01 -> 00; the down
  // order is its reverse. Any change of both bits at once is illegal.
  // --------------------------------------------------------------------------
  always_comb begin
    w_up  = 1'b0;
    w_dn  = 1'b0;
    w_bad = 1'b0;
    case ({ab_q, w_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up  = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_dn  = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_bad = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 1: state and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_ST_INIT;
      ab_q    <= 2'b00;
      count_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      count_q <= count_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next state. INIT lasts exactly one clock, whether or not
  // clr is asserted during it.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_INIT:  state_d = c_ST_TRACK;
      c_ST_TRACK: state_d = c_ST_TRACK;
      default:    state_d = c_ST_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: datapath next values.
  // The phase register always follows the inputs, including on a clr cycle,
  // so an edge coinciding with clr is consumed and never counted later.
  // --------------------------------------------------------------------------
  always_comb begin
    ab_d    = w_ab;
    count_d = count_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;

    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == c_ST_TRACK) begin
      if (w_up) begin
        count_d = count_q + W'(1);
        dir_d   = 1'b1;
        step_d  = 1'b1;
      end else if (w_dn) begin
        count_d = count_q - W'(1);
        dir_d   = 1'b0;
        step_d  = 1'b1;
      end else if (w_bad) begin
        err_d   = 1'b1;
      end
    end
    // In INIT without clr only the phase register loads; nothing is counted.
  end

  // --------------------------------------------------------------------------
  // Outputs are driven straight from registers
  // --------------------------------------------------------------------------
  assign count = count_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_decoder
//  Description : Self-checking bench for quad_decoder. Scenario tasks drive
//                the encoder phases and compare against a behavioural model
//                based on phase position arithmetic (mod 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_quad_decoder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         a;
  logic         b;
  logic         clr;
  logic [W-1:0] count;
  logic         step;
  logic         dir;
  logic         err;

  int n_tests;
  int n_fail;

  // Reference model state
  bit m_init;
  int m_pos;      // phase position 0..3 of the last sampled phase
  int m_count;
  bit m_step;
  bit m_dir;
  bit m_err;

  quad_decoder #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .clr   (clr),
    .count (count),
    .step  (step),
    .dir   (dir),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position of a phase pair along the up sequence 00,10,11,01
  function automatic int phase_pos(input logic pa, input logic pb);
    if (!pa && !pb) return 0;
    if ( pa && !pb) return 1;
    if ( pa &&  pb) return 2;
    return 3;
  endfunction

  // Phase pair for a position (inverse of phase_pos)
  function automatic logic [1:0] pos_ab(input int p);
    case (p & 3)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    m_init  = 1'b1;
    m_pos   = 0;
    m_count = 0;
    m_step  = 1'b0;
    m_dir   = 1'b0;
    m_err   = 1'b0;
  endtask

  // One rising edge of the model
  task automatic model_clock(input logic pa, input logic pb, input logic pc);
    int now;
    int delta;
    now    = phase_pos(pa, pb);
    delta  = (now - m_pos + 4) % 4;
    m_step = 1'b0;
    if (pc) begin
      m_count = 0;
      m_err   = 1'b0;
    end else if (!m_init) begin
      if (delta == 1) begin
        m_count = (m_count + 1) % (1 << W);
        m_dir   = 1'b1;
        m_step  = 1'b1;
      end else if (delta == 3) begin
        m_count = (m_count + (1 << W) - 1) % (1 << W);
        m_dir   = 1'b0;
        m_step  = 1'b1;
      end else if (delta == 2) begin
        m_err   = 1'b1;
      end
    end
    m_init = 1'b0;
    m_pos  = now;
  endtask

  // Apply inputs, clock once, update model, land 1 time unit after the edge
  task automatic cyc(input logic [1:0] ab, input logic c);
    a   = ab[1];
    b   = ab[0];
    clr = c;
    @(posedge clk);
    model_clock(ab[1], ab[0], c);
    #1;
  endtask

  // Assert reset with the given phases held, release on a falling edge
  task automatic do_reset(input logic [1:0] ab);
    a   = ab[1];
    b   = ab[0];
    clr = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int steps_seen;
    do_reset(2'b11);
    rst = 1'b0;
    #1;
    n_tests++;
    if (count !== 8'd0 || step !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got count=%0d step=%b dir=%b err=%b, want 0 0 0 0",
               count, step, dir, err);
    end
    @(negedge clk);
    rst = 1'b1;
    steps_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(2'b11, 1'b0);
      if (step === 1'b1) steps_seen++;
    end
    n_tests++;
    if (count !== 8'd0 || steps_seen != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL init_suppress: got count=%0d steps=%0d err=%b, want 0 0 0",
               count, steps_seen, err);
    end
  endtask

  task automatic test_up_down();
    int pulses;
    int wide;
    do_reset(2'b00);
    cyc(2'b00, 1'b0);
    pulses = 0;
    wide   = 0;
    for (int e = 1; e <= 8; e++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(pos_ab(e), 1'b0);
        if (step === 1'b1) begin
          pulses++;
          if (k != 0) wide++;
        end
      end
    end
    n_tests++;
    if (count !== 8'd8 || dir !== 1'b1 || pulses != 8 || wide != 0) begin
      n_fail++;
      $display("FAIL up_8: got count=%0d dir=%b pulses=%0d late=%0d, want 8 1 8 0",
               count, dir, pulses, wide);
    end
    for (int e = 1; e <= 3; e++) begin
      for (int k = 0; k < 4; k++) cyc(pos_ab(8 - e), 1'b0);
    end
    n_tests++;
    if (count !== 8'd5 || dir !== 1'b0) begin
      n_fail++;
      $display("FAIL down_3: got count=%0d dir=%b, want 5 0", count, dir);
    end
  endtask

  task automatic test_wrap();
    int p;
    do_reset(2'b00);
    cyc(2'b00, 1'b0);
    p = 0;
    for (int i = 0; i < 255; i++) begin
      p++;
      cyc(pos_ab(p), 1'b0);
    end
    n_tests++;
    if (count !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_reach255: got count=%0d, want 255", count);
    end
    p++;
    cyc(pos_ab(p), 1'b0);
    n_tests++;
    if (count !== 8'd0 || step !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_up: got count=%0d step=%b, want 0 1", count, step);
    end
    p--;
    cyc(pos_ab(p), 1'b0);
    p--;
    cyc(pos_ab(p), 1'b0);
    n_tests++;
    if (count !== 8'd254 || dir !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_down: got count=%0d dir=%b, want 254 0", count, dir);
    end
  endtask

  task automatic test_err();
    do_reset(2'b00);
    cyc(2'b00, 1'b0);
    cyc(2'b11, 1'b0);
    n_tests++;
    if (err !== 1'b1 || count !== 8'd0 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set: got err=%b count=%0d step=%b, want 1 0 0", err, count, step);
    end
    cyc(2'b01, 1'b0);
    n_tests++;
    if (count !== 8'd1 || err !== 1'b1 || step !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got count=%0d err=%b step=%b, want 1 1 1", count, err, step);
    end
    cyc(2'b01, 1'b1);
    n_tests++;
    if (count !== 8'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: got count=%0d err=%b, want 0 0", count, err);
    end
  endtask

  task automatic test_clr_edge();
    int late;
    do_reset(2'b00);
    cyc(2'b00, 1'b0);
    cyc(2'b10, 1'b0);
    cyc(2'b11, 1'b0);
    cyc(2'b01, 1'b1);
    n_tests++;
    if (count !== 8'd0 || step !== 1'b0 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_edge: got count=%0d step=%b dir=%b, want 0 0 1", count, step, dir);
    end
    late = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 1'b0);
      if (step === 1'b1 || count !== 8'd0) late++;
    end
    n_tests++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL clr_consumed: got %0d cycles with a late count, want 0", late);
    end
  endtask

  task automatic test_back_to_back();
    int run;
    do_reset(2'b00);
    cyc(2'b00, 1'b0);
    run = 0;
    cyc(2'b10, 1'b0); if (step === 1'b1) run++;
    cyc(2'b11, 1'b0); if (step === 1'b1) run++;
    cyc(2'b01, 1'b0); if (step === 1'b1) run++;
    n_tests++;
    if (count !== 8'd3 || run != 3) begin
      n_fail++;
      $display("FAIL b2b: got count=%0d step_cycles=%0d, want 3 3", count, run);
    end
    a = 1'b0;
    b = 1'b0;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (count !== 8'd0 || step !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got count=%0d step=%b dir=%b err=%b, want 0 0 0 0",
               count, step, dir, err);
    end
    @(negedge clk);
    rst = 1'b1;
    // Phases are now 00 after release; a quick up edge must be counted once
    cyc(2'b00, 1'b0);
    cyc(2'b10, 1'b0);
    n_tests++;
    if (count !== 8'd1 || step !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_count: got count=%0d step=%b, want 1 1", count, step);
    end
  endtask

  task automatic test_random();
    int p;
    int r;
    int bad;
    logic [1:0] ab;
    logic c;
    p = int'($urandom_range(0, 3));
    do_reset(pos_ab(p));
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      p = p + 1;
      else if (r < 75) p = p + 3;
      else if (r < 80) p = p + 2;
      ab = pos_ab(p);
      p  = p & 3;
      c  = ($urandom_range(0, 49) == 0) || (i == 0 && r < 50);
      cyc(ab, c);
      n_tests++;
      if (count !== m_count[W-1:0] || step !== m_step || dir !== m_dir || err !== m_err) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_%0d: got count=%0d step=%b dir=%b err=%b, want %0d %b %b %b",
                   i, count, step, dir, err, m_count, m_step, m_dir, m_err);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    clr = 1'b0;
    model_reset();
    test_reset();
    test_up_down();
    test_wrap();
    test_err();
    test_clr_edge();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
